ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-master arbiter that shares the single external RAM port (24-bit address, 16-bit data, synchronous read) between the risc8 CPU (master 0) and a second requester such as a program loader or DMA engine (master 1).
- Sits between the CPU's processor_port RAM signals and the memory instance.
- Provides round-robin arbitration, optional locked bursts with a forced-release limit, and tagged routing of read data back to the issuing master.

Parameters:
- AW, 24, RAM address width.
- DW, 16, RAM data width.
- RD_LAT, 1, cycles from an issued read to valid ram_rd_data (range 1..4).
- MAX_HOLD, 16, maximum granted accesses per locked ownership before forced release (range 2..255).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- m0_req  in  1  master 0 access request
- m0_we  in  1  master 0 write (1) / read (0)
- m0_lock  in  1  master 0 requests to keep ownership after this access
- m0_addr  in  AW  master 0 address
- m0_wdata  in  DW  master 0 write data
- m0_gnt  out  1  master 0 access issued to RAM this cycle
- m0_rvalid  out  1  master 0 read data valid
- m0_rdata  out  DW  master 0 read data
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
- ram_addr  out  AW  RAM address
- ram_wr_data  out  DW  RAM write data
- ram_wr_en  out  1  RAM write strobe
- ram_rd_en  out  1  RAM read strobe
- ram_rd_data  in  DW  RAM read data

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, rr_last=1 (so master 0 is preferred first), hold_cnt=0, read-tag pipeline cleared.
  - All gnt, rvalid, ram_wr_en and ram_rd_en are 0; ram_addr and ram_wr_data are 0.
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: a locked owner.
- Grant timing:
  - Grant is combinational from state and req. m*_gnt=1 in the same cycle the access drives the RAM pins; there is zero-cycle arbitration latency.
  - The granted master's addr/wdata are muxed onto the RAM pins. ram_wr_en=we and ram_rd_en=!we.
  - With no grant, both enables are 0 and addr/wdata are driven to 0.
  - At most one gnt is high per cycle, and ram_wr_en and ram_rd_en are never both high.
- Arbitration in IDLE:
  - If only one master requests, it wins.
  - If both request, the master != rr_last wins.
  - On a grant, rr_last is set to the winner. If the winner's lock=1, the next state is OWN<winner> with hold_cnt=1; otherwise the state stays IDLE.
- In OWN_x:
  - Only master x can be granted; the other master stalls with gnt=0.
  - Each grant to x increments hold_cnt.
  - Exit to IDLE happens after a granted access with lock=0, or after the access that brings hold_cnt to MAX_HOLD (forced release).
  - If x has req=0 in OWN_x, the state returns to IDLE next cycle with no grant that cycle (one bubble).
  - After a forced release, rr_last=x, so a waiting master gets the next grant.
- Handoff: exit from OWN_x is registered, and IDLE arbitrates in the following cycle. This gives no bubble when the other master is waiting.
- Read return:
  - A shift pipeline of depth RD_LAT carries {valid, master_id} for each issued read.
  - m<id>_rvalid=1 exactly RD_LAT cycles after the read's gnt cycle. Writes produce no rvalid.
  - m0_rdata and m1_rdata both equal ram_rd_data; only rvalid is steered.
- Back-to-back reads from alternating masters return in issue order, one per cycle.
- Reset mid-read: the pipeline is cleared, and no rvalid is ever produced for in-flight reads.
- Requests may change every cycle. A master must hold req/addr/we/wdata stable until it sees gnt.

Decomposition:
- Shared package ram_arb_pkg:
  - typedef enum arb_state_t {IDLE, OWN0, OWN1}
  - typedef logic master_id_t
  - typedef struct rd_tag_t {valid, id}
  - constants NUM_MASTERS=2 and default MAX_HOLD.
- One sub-module, ram_rd_tag_pipe: the parameterised RD_LAT shift register of rd_tag_t with async active-low clear.
- Arbitration FSM, hold counter and muxes live in ram_arbiter.

Test Plan:
1. Reset, then m0 reads addr 0x000010 (RAM holds 0xBEEF) -> m0_gnt same cycle, ram_rd_en=1, m0_rvalid=1 with m0_rdata=0xBEEF one cycle later, m1_rvalid=0.
2. Both masters request with no lock for 4 cycles after reset -> grants m0,m1,m0,m1; ram_addr alternates accordingly; rvalid tags follow one cycle later in the same order.
3. m0 writes 8 words with lock=1 (lock=0 on the last) while m1 requests continuously -> m1_gnt=0 for 8 cycles, then m1 granted the next cycle with no bubble.
4. m1 locked with MAX_HOLD=16 and continuous requests, m0 waiting -> exactly 16 m1 grants, then m0 granted; m1 regains after m0's access if m0 is unlocked.
5. Issue an m1 read, then assert rst low before the return cycle -> no m1_rvalid; all outputs 0 during reset; after release m0 is preferred on a simultaneous request.
6. Randomised mix of requests checking gnt exclusivity, enable exclusivity, and exactly one rvalid per read at RD_LAT=1 and RD_LAT=3.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
//   arb_state_t : arbitration FSM state (no owner / locked owner 0 / locked owner 1)
//   master_id_t : master index carried with each issued read
//   rd_tag_t    : {valid, id} entry of the read-return tag pipeline
package ram_arb_pkg;

  localparam int NUM_MASTERS  = 2;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// Read-return tag pipeline: delays the {valid, id} tag of each issued read by
// DEPTH cycles so it lines up with the RAM's read data.
//   clk, rst_n : clock, asynchronous active-low clear (drops in-flight tags)
//   i_tag      : tag of the access issued this cycle
//   o_tag      : tag of the access issued DEPTH cycles ago
module ram_rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single synchronous-read RAM port.
// Master 0 is the CPU, master 1 a loader/DMA. Round-robin between unlocked
// requests, locked bursts with a forced release after MAX_HOLD accesses, and
// read-valid steering back to the master that issued the read.
//   clk, rst          : clock, asynchronous active-low reset
//   m*_req/we/lock    : request, write(1)/read(0), keep ownership after access
//   m*_addr/wdata     : access address and write data
//   m*_gnt            : access driven onto the RAM pins this cycle
//   m*_rvalid/rdata   : read data return (rdata is shared, rvalid is steered)
//   ram_*             : RAM port
//
// state | meaning
// IDLE  | no owner, round-robin between requesters
// OWN0  | master 0 holds a locked burst, master 1 stalls
// OWN1  | master 1 holds a locked burst, master 0 stalls
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW       = 24,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic          ram_wr_en,
  output logic          ram_rd_en,
  input  logic [DW-1:0] ram_rd_data
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  arb_state_t r_state;
  master_id_t r_rr_last;
  logic [7:0] r_hold_cnt;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_any;
  master_id_t w_win;
  logic       w_lock;
  logic       w_we;
  logic [7:0] w_hold_next;
  rd_tag_t    w_tag_in;
  rd_tag_t    w_tag_out;

  // Grants are gated by rst so the RAM pins stay quiet while reset is held.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst) begin
      case (r_state)
        IDLE: begin
          // On contention the master that did not win last time goes first.
          w_gnt0 = m0_req & (~m1_req | r_rr_last);
          w_gnt1 = m1_req & (~m0_req | ~r_rr_last);
        end
        OWN0:    w_gnt0 = m0_req;
        OWN1:    w_gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  assign w_any       = w_gnt0 | w_gnt1;
  assign w_win       = w_gnt1;
  assign w_lock      = w_gnt1 ? m1_lock : m0_lock;
  assign w_we        = w_gnt1 ? m1_we : m0_we;
  assign w_hold_next = r_hold_cnt + 8'd1;

  assign m0_gnt      = w_gnt0;
  assign m1_gnt      = w_gnt1;
  assign ram_addr    = w_gnt0 ? m0_addr  : (w_gnt1 ? m1_addr  : '0);
  assign ram_wr_data = w_gnt0 ? m0_wdata : (w_gnt1 ? m1_wdata : '0);
  assign ram_wr_en   = w_any & w_we;
  assign ram_rd_en   = w_any & ~w_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_rr_last  <= 1'b1;
      r_hold_cnt <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_rr_last <= w_win;
            if (w_lock) begin
              r_state    <= w_win ? OWN1 : OWN0;
              r_hold_cnt <= 8'd1;
            end
          end
        end
        OWN0, OWN1: begin
          if (w_any) begin
            r_rr_last <= w_win;
            // Forced release keeps rr_last on the owner, so a waiting master wins next.
            if (!w_lock || w_hold_next == HOLD_MAX) begin
              r_state    <= IDLE;
              r_hold_cnt <= 8'd0;
            end else begin
              r_hold_cnt <= w_hold_next;
            end
          end else begin
            // Owner dropped its request: give up ownership, one bubble.
            r_state    <= IDLE;
            r_hold_cnt <= 8'd0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_hold_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign w_tag_in = '{valid: ram_rd_en, id: w_win};

  ram_rd_tag_pipe #(
    .DEPTH(RD_LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .rst_n(rst),
    .i_tag(w_tag_in),
    .o_tag(w_tag_out)
  );

  assign m0_rvalid = w_tag_out.valid & (w_tag_out.id == 1'b0);
  assign m1_rvalid = w_tag_out.valid & (w_tag_out.id == 1'b1);
  assign m0_rdata  = ram_rd_data;
  assign m1_rdata  = ram_rd_data;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int MAXH = 16;

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [23:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;

  logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
  logic [15:0] a_m0_rdata, a_m1_rdata, a_ram_wr_data, a_ram_rd_data;
  logic [23:0] a_ram_addr;
  logic        a_ram_wr_en, a_ram_rd_en;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [15:0] b_m0_rdata, b_m1_rdata, b_ram_wr_data, b_ram_rd_data;
  logic [23:0] b_ram_addr;
  logic        b_ram_wr_en, b_ram_rd_en;

  ram_arbiter #(.AW(24), .DW(16), .RD_LAT(1), .MAX_HOLD(MAXH)) u_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .ram_addr(a_ram_addr), .ram_wr_data(a_ram_wr_data), .ram_wr_en(a_ram_wr_en),
    .ram_rd_en(a_ram_rd_en), .ram_rd_data(a_ram_rd_data)
  );

  ram_arbiter #(.AW(24), .DW(16), .RD_LAT(3), .MAX_HOLD(MAXH)) u_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .ram_addr(b_ram_addr), .ram_wr_data(b_ram_wr_data), .ram_wr_en(b_ram_wr_en),
    .ram_rd_en(b_ram_rd_en), .ram_rd_data(b_ram_rd_data)
  );

  function automatic logic [15:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return (i == 16) ? 16'hBEEF : {b ^ 8'h5A, b};
  endfunction

  // RAM models: one-cycle sync read (A) and three-cycle read latency (B)
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] ra;
  logic [15:0] rb [3];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= pat(i);
    end else if (a_ram_wr_en) begin
      mem_a[a_ram_addr[7:0]] <= a_ram_wr_data;
    end
    ra <= mem_a[a_ram_addr[7:0]];
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= pat(i);
    end else if (b_ram_wr_en) begin
      mem_b[b_ram_addr[7:0]] <= b_ram_wr_data;
    end
    rb[0] <= mem_b[b_ram_addr[7:0]];
    rb[1] <= rb[0];
    rb[2] <= rb[1];
  end

  assign a_ram_rd_data = ra;
  assign b_ram_rd_data = rb[2];

  // Reference model and scoreboard state
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          m_st;
  bit          m_rr;
  int          m_hold;
  logic [15:0] shadow [256];
  exp_t        qa[$];
  exp_t        qb[$];
  int          rd_issued, rv_a, rv_b;
  bit          e0, e1;
  logic        s_g0, s_g1, s_rv0, s_rv1;
  logic [15:0] s_rd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_rr = 1'b1;
    m_hold = 0;
    qa.delete();
    qb.delete();
    rd_issued = 0;
    rv_a = 0;
    rv_b = 0;
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
  endtask

  // One clock: check at negedge, advance model at posedge, return 1ns after it.
  task automatic tick();
    logic [23:0] ex_addr;
    logic [15:0] ex_wd;
    bit          ex_we, ex_re, hit, lk, w;
    exp_t        ent;
    @(negedge clk);
    e0 = 1'b0;
    e1 = 1'b0;
    if (rst) begin
      if (m_st == 1) e0 = m0_req;
      else if (m_st == 2) e1 = m1_req;
      else begin
        e0 = m0_req && (!m1_req || m_rr);
        e1 = m1_req && !e0;
      end
    end
    ex_addr = e0 ? m0_addr : (e1 ? m1_addr : 24'h0);
    ex_wd   = e0 ? m0_wdata : (e1 ? m1_wdata : 16'h0);
    ex_we   = (e0 && m0_we) || (e1 && m1_we);
    ex_re   = (e0 && !m0_we) || (e1 && !m1_we);
    chk("a_gnt", {a_m1_gnt, a_m0_gnt}, {e1, e0});
    chk("b_gnt", {b_m1_gnt, b_m0_gnt}, {e1, e0});
    chk("a_ram_addr", a_ram_addr, ex_addr);
    chk("a_ram_wr_data", a_ram_wr_data, ex_wd);
    chk("a_ram_en", {a_ram_wr_en, a_ram_rd_en}, {ex_we, ex_re});
    chk("b_ram_en", {b_ram_wr_en, b_ram_rd_en}, {ex_we, ex_re});
    chk("a_gnt_excl", a_m0_gnt & a_m1_gnt, 0);
    chk("a_en_excl", a_ram_wr_en & a_ram_rd_en, 0);

    hit = (qa.size() > 0) && (qa[0].due == cyc);
    if (hit) begin
      chk("a_rvalid", {a_m1_rvalid, a_m0_rvalid}, qa[0].id ? 2'b10 : 2'b01);
      chk("a_rdata", qa[0].id ? a_m1_rdata : a_m0_rdata, qa[0].data);
      void'(qa.pop_front());
    end else begin
      chk("a_rvalid", {a_m1_rvalid, a_m0_rvalid}, 2'b00);
    end
    hit = (qb.size() > 0) && (qb[0].due == cyc);
    if (hit) begin
      chk("b_rvalid", {b_m1_rvalid, b_m0_rvalid}, qb[0].id ? 2'b10 : 2'b01);
      chk("b_rdata", qb[0].id ? b_m1_rdata : b_m0_rdata, qb[0].data);
      void'(qb.pop_front());
    end else begin
      chk("b_rvalid", {b_m1_rvalid, b_m0_rvalid}, 2'b00);
    end
    rv_a += int'(a_m0_rvalid) + int'(a_m1_rvalid);
    rv_b += int'(b_m0_rvalid) + int'(b_m1_rvalid);

    if (ex_re) begin
      ent.id   = e1;
      ent.data = shadow[ex_addr[7:0]];
      ent.due  = cyc + 1;
      qa.push_back(ent);
      ent.due  = cyc + 3;
      qb.push_back(ent);
      rd_issued++;
    end
    s_g0  = a_m0_gnt;
    s_g1  = a_m1_gnt;
    s_rv0 = a_m0_rvalid;
    s_rv1 = a_m1_rvalid;
    s_rd0 = a_m0_rdata;

    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (e0 || e1) begin
      w  = e1;
      lk = e1 ? m1_lock : m0_lock;
      if (ex_we) shadow[ex_addr[7:0]] = ex_wd;
      m_rr = w;
      if (m_st == 0) begin
        if (lk) begin
          m_st = w ? 2 : 1;
          m_hold = 1;
        end
      end else begin
        m_hold++;
        if (!lk || m_hold == MAXH) begin
          m_st = 0;
          m_hold = 0;
        end
      end
    end else if (m_st != 0) begin
      m_st = 0;
      m_hold = 0;
    end
    cyc++;
    #1;
  endtask

  initial begin
    int g0cnt, g1cnt;
    logic [3:0] seq;
    rst = 1'b0;
    {m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock} = '0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b1;

    // 1: single m0 read of 0x10
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 24'h000010;
    tick();
    chk("t1_m0_gnt", s_g0, 1);
    m0_req = 1'b0;
    tick();
    chk("t1_m0_rvalid", s_rv0, 1);
    chk("t1_m0_rdata", s_rd0, 16'hBEEF);
    chk("t1_m1_rvalid", s_rv1, 0);
    tick();
    tick();

    // 2: fresh reset, then both masters unlocked reads alternate
    rst = 1'b0;
    model_reset();
    tick();
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 24'h000020;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 24'h000030;
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seq = {seq[2:0], s_g1};
      if (s_g0) m0_addr = m0_addr + 24'd1;
      if (s_g1) m1_addr = m1_addr + 24'd1;
    end
    chk("t2_grant_order", seq, 4'b0101);
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    tick();

    // 3: m0 locked 8-word write burst while m1 waits
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 24'h000040;
    g0cnt = 0; g1cnt = 0;
    for (int k = 0; k < 8; k++) begin
      m0_req = 1'b1; m0_we = 1'b1; m0_lock = (k < 7);
      m0_addr = 24'h000080 + 24'(k);
      m0_wdata = 16'h1000 + 16'(k);
      tick();
      g0cnt += int'(s_g0);
      g1cnt += int'(s_g1);
    end
    chk("t3_m0_grants", g0cnt, 8);
    chk("t3_m1_stalled", g1cnt, 0);
    m0_req = 1'b0; m0_lock = 1'b0;
    tick();
    chk("t3_m1_no_bubble", s_g1, 1);
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 24'h000083;
    tick();
    m0_req = 1'b0;
    tick();
    chk("t3_readback", s_rd0, 16'h1003);
    tick();
    tick();

    // 4: m1 locked continuously, forced release after MAX_HOLD
    m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b1; m1_addr = 24'h000050;
    g1cnt = 0;
    tick();
    g1cnt += int'(s_g1);
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 24'h000060;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (s_g0) break;
      g1cnt += int'(s_g1);
    end
    chk("t4_m1_grants", g1cnt, MAXH);
    chk("t4_m0_granted", s_g0, 1);
    m0_req = 1'b0;
    tick();
    chk("t4_m1_regain", s_g1, 1);
    m1_lock = 1'b0;
    tick();
    m1_req = 1'b0;
    tick();
    tick();
    tick();
    tick();

    // 5: reset with an m1 read in flight
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 24'h000070;
    tick();
    chk("t5_m1_gnt", s_g1, 1);
    rst = 1'b0;
    model_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 24'h000071;
    tick();
    chk("t5_m1_rvalid_killed", s_rv1, 0);
    chk("t5_gnt_in_reset", {s_g1, s_g0}, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_m0_first", s_g0, 1);
    m0_req = 1'b0; m1_req = 1'b0;
    for (int k = 0; k < 5; k++) tick();

    // 6: random traffic, requests held until granted
    for (int k = 0; k < 400; k++) begin
      if (!m0_req || s_g0) begin
        m0_req   = ($urandom_range(0, 3) != 0);
        m0_we    = $urandom_range(0, 1) == 1;
        m0_lock  = ($urandom_range(0, 3) == 0);
        m0_addr  = {16'h0, 8'($urandom)};
        m0_wdata = 16'($urandom);
      end
      if (!m1_req || s_g1) begin
        m1_req   = ($urandom_range(0, 3) != 0);
        m1_we    = $urandom_range(0, 1) == 1;
        m1_lock  = ($urandom_range(0, 3) == 0);
        m1_addr  = {16'h0, 8'($urandom)};
        m1_wdata = 16'($urandom);
      end
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("t6_a_one_rvalid_per_read", rv_a, rd_issued);
    chk("t6_b_one_rvalid_per_read", rv_b, rd_issued);
    chk("t6_a_pending", qa.size(), 0);
    chk("t6_b_pending", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
